// File: rtl/nth_one_fsm_if.sv
// Bus interface for nth_one_fsm.
// Groups the per-channel control, event and status signals of the detector.
//   en      global enable (master -> slave)
//   clr     per-channel synchronous clear (master -> slave)
//   din     per-channel event input (master -> slave)
//   dout    per-channel pulse on every Nth qualified din=1 (slave -> master)
//   state   one-hot state, channel c at [c*SW +: SW] (slave -> master)
//   halted  per-channel one-shot halt indication (slave -> master)
//   err     sticky illegal-state flag (slave -> master)
interface nth_one_fsm_if #(
    parameter int CH = 2,
    parameter int N  = 2
);
    localparam int SW = N + 2;

    logic              en;
    logic [CH-1:0]     clr;
    logic [CH-1:0]     din;
    logic [CH-1:0]     dout;
    logic [CH*SW-1:0]  state;
    logic [CH-1:0]     halted;
    logic              err;

    modport master (
        output en, clr, din,
        input  dout, state, halted, err
    );

    modport slave (
        input  en, clr, din,
        output dout, state, halted, err
    );
endinterface

// File: rtl/nth_one_fsm.sv
// Multi-channel "every Nth din=1" detector.
// Each channel walks a one-hot chain IDLE -> C0 .. C(N-1) and pulses dout on
// the qualified din=1 seen in C(N-1). In one-shot mode the channel then parks
// in HALT until cleared. A non-one-hot state is recovered to IDLE and latched
// into a sticky err flag.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-low
//   bus   nth_one_fsm_if slave modport (en, clr, din in; dout, state, halted, err out)
module nth_one_fsm #(
    parameter int CH      = 2,
    parameter int N       = 2,
    parameter int ONESHOT = 0,
    parameter int REG_OUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    nth_one_fsm_if.slave   bus
);
    localparam int SW = N + 2;

    // Named one-hot codes; the intermediate counting states C1..C(N-2) are
    // reached by shifting, so only the anchors of the chain are listed.
    typedef enum logic [SW-1:0] {
        S_IDLE = SW'(1),
        S_C0   = SW'(2),
        S_LAST = SW'(1) << N,
        S_HALT = SW'(1) << (N + 1)
    } state_e;

    logic [CH-1:0][SW-1:0] st_q;
    logic [CH-1:0]         pulse;
    logic [CH-1:0]         dout_q;
    logic [CH-1:0]         halted;
    logic                  err_q;

    // Pulse qualification and halt decode per channel.
    always_comb begin
        pulse  = '0;
        halted = '0;
        for (int c = 0; c < CH; c++) begin
            pulse[c]  = bus.en & ~bus.clr[c] & (st_q[c] == S_LAST) & bus.din[c];
            halted[c] = (st_q[c] == S_HALT);
        end
    end

    // Illegal-state recovery runs even while en=0 so a corrupted channel
    // never stays frozen in a state the chain cannot leave.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                st_q[c] <= S_IDLE;
            end
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= pulse;
            for (int c = 0; c < CH; c++) begin
                if ($countones(st_q[c]) != 1) begin
                    err_q <= 1'b1;
                end
                if (bus.clr[c] || ($countones(st_q[c]) != 1)) begin
                    st_q[c] <= S_IDLE;
                end else if (bus.en) begin
                    if (st_q[c] == S_IDLE) begin
                        st_q[c] <= S_C0;
                    end else if ((st_q[c] != S_HALT) && bus.din[c]) begin
                        if (st_q[c] == S_LAST) begin
                            st_q[c] <= (ONESHOT != 0) ? S_HALT : S_C0;
                        end else begin
                            st_q[c] <= st_q[c] << 1;
                        end
                    end
                end
            end
        end
    end

    assign bus.dout   = (REG_OUT != 0) ? dout_q : pulse;
    assign bus.state  = st_q;
    assign bus.halted = halted;
    assign bus.err    = err_q;
endmodule
